// File: rtl/lifo_stack_if.sv
// Command/status bundle between a stack command issuer and lifo_stack.
// The optional `top` peek signal exists only when LIFO_PEEK_EN is defined.
interface lifo_stack_if #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 4
);
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] din;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [PTR_W:0]    sp;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
`ifdef LIFO_PEEK_EN
  logic [DATA_W-1:0] top;
`endif

  // Command issuer side
  modport master (
    output push, pop, din, clr_err,
    input  dout, dout_valid, sp, empty, full, overflow, underflow
`ifdef LIFO_PEEK_EN
    , input top
`endif
  );

  // Stack storage side
  modport slave (
    input  push, pop, din, clr_err,
    output dout, dout_valid, sp, empty, full, overflow, underflow
`ifdef LIFO_PEEK_EN
    , output top
`endif
  );
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack: register-array LIFO with a PTR_W+1 bit stack pointer (entry
// count), registered pop data, and sticky overflow/underflow flags.
// Define LIFO_PEEK_EN to add a combinational `top` peek output.
module lifo_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic          clk,
  input  logic          reset,   // async, active low
  lifo_stack_if.slave   bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    sp_q, sp_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [PTR_W-1:0]  top_idx;
  logic              is_empty, is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == (PTR_W+1)'(DEPTH));
  // Index of the current top entry; meaningless (and unused) while empty.
  assign top_idx  = PTR_W'(sp_q - (PTR_W+1)'(1));

  // Command decode: next pointer, pop data, error flags and write port.
  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    // Clear first so a same-edge error event below overrides it.
    ovf_d  = ovf_q & ~bus.clr_err;
    unf_d  = unf_q & ~bus.clr_err;
    we     = 1'b0;
    waddr  = sp_q[PTR_W-1:0];
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + 1'b1;
        end
      end
      2'b01: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          dout_d = mem_q[top_idx];
          dv_d   = 1'b1;
          sp_d   = sp_q - 1'b1;
        end
      end
      2'b11: begin
        if (is_empty) begin
          // Nothing to pop: behaves as a plain push into slot 0.
          we    = 1'b1;
          waddr = '0;
          sp_d  = (PTR_W+1)'(1);
        end else begin
          // Replace-top: return old top, overwrite it in place. Legal when full.
          dout_d = mem_q[top_idx];
          dv_d   = 1'b1;
          we     = 1'b1;
          waddr  = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Pointer, output and flag registers; async reset empties the stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q   <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= bus.din;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.sp         = sp_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;

`ifdef LIFO_PEEK_EN
  assign bus.top = is_empty ? '0 : mem_q[top_idx];
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: vector table for LIFO order, underflow,
// clear and simultaneous push/pop, plus hand sequences for fill/overflow
// and asynchronous reset.
module tb_lifo_stack;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  lifo_stack_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

  lifo_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic       clr;
    logic [4:0] sp;
    logic [7:0] dout;
    logic       dv;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic [7:0] d, input logic c);
    bus.push = p; bus.pop = q; bus.din = d; bus.clr_err = c;
  endtask

  // Apply one command across one rising edge, leave inputs idle afterwards.
  task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c);
    drive(p, q, d, c);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_state(input string tag, input logic [4:0] sp, input logic [7:0] dout,
                           input logic dv, input logic ovf, input logic unf);
    chk({tag, ".sp"},    32'(bus.sp),         32'(sp));
    chk({tag, ".dout"},  32'(bus.dout),       32'(dout));
    chk({tag, ".dv"},    32'(bus.dout_valid), 32'(dv));
    chk({tag, ".ovf"},   32'(bus.overflow),   32'(ovf));
    chk({tag, ".unf"},   32'(bus.underflow),  32'(unf));
    chk({tag, ".empty"}, 32'(bus.empty),      32'(sp == 5'd0));
    chk({tag, ".full"},  32'(bus.full),       32'(sp == 5'd16));
  endtask

  initial begin
    //           push pop din   clr  sp    dout  dv ovf unf
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h33, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 5'd1, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd0, 8'h11, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h05, 1'b0, 5'd1, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h06, 1'b0, 5'd2, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'h77, 1'b0, 5'd2, 8'h06, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 1'b0, 5'd1, 8'h77, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 8'h05, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 8'h44, 1'b0, 5'd1, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 8'h44, 1'b1, 1'b0, 1'b0};

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #50;
    chk_state("reset", 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("idle", 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
      chk_state($sformatf("vec%0d", i), vecs[i].sp, vecs[i].dout, vecs[i].dv,
                vecs[i].ovf, vecs[i].unf);
    end

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    chk_state("fill", 5'd16, 8'h44, 1'b0, 1'b0, 1'b0);
`ifdef LIFO_PEEK_EN
    chk("peek.full", 32'(bus.top), 32'h0F);
`endif
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    chk_state("ovf", 5'd16, 8'h44, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("pop_after_ovf", 5'd15, 8'h0F, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hBB, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk_state("ovf_clr", 5'd16, 8'h0F, 1'b0, 1'b0, 1'b0);
    // Replace-top while full: legal, no overflow.
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk_state("repl_full", 5'd16, 8'hBB, 1'b1, 1'b0, 1'b0);
`ifdef LIFO_PEEK_EN
    chk("peek.repl", 32'(bus.top), 32'h55);
`endif
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("pop_repl", 5'd15, 8'h55, 1'b1, 1'b0, 1'b0);

    // Async reset mid-operation with sp = 5 and underflow set.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
    chk_state("pre_arst", 5'd5, 8'h00, 1'b0, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk_state("arst", 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hC3, 1'b0);
    chk_state("post_arst_push", 5'd1, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef LIFO_PEEK_EN
    chk("peek.post", 32'(bus.top), 32'hC3);
`endif
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("post_arst_pop", 5'd0, 8'hC3, 1'b1, 1'b0, 1'b0);
`ifdef LIFO_PEEK_EN
    chk("peek.empty", 32'(bus.top), 32'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
